fx2_fifo_arbiter: RTL
=====================

// Module: fx2_fifo_arbiter
// PURPOSE
//   Shares the FX2 slave-FIFO bus between two internal requesters: an OUT reader
//   (host->device bytes drained from EP2) and an IN writer (device->host bytes
//   pushed into EP6). It sequences FIFO select, turnaround, read/write strobes and
//   PKTEND, and arbitrates direction round-robin with a per-grant burst limit.
//   It sits between the FX2 pins and the application byte streams.
// PARAMETERS
//   MAX_BURST   64     max bytes moved per grant before re-arbitration (>=1)
//   TURNAROUND  2      cycles held in SEL_* after faddr/sloe change (>=1)
//   OUT_ADDR    2'b00  faddr value for EP2 (OUT endpoint)
//   IN_ADDR     2'b10  faddr value for EP6 (IN endpoint)
// PORTS
//   clk       in   1  system clock; all FX2 signals sampled/driven on posedge
//   reset     in   1  asynchronous, active-low reset
//   flaga     in   1  EP2 empty flag, low = empty
//   flagd     in   1  EP6 full flag, low = full
//   fdata     io   8  FX2 data bus; driven only in IN states, else high-Z
//   faddr     out  2  FIFO address select
//   sloe      out  1  FIFO output enable, active low
//   slrd      out  1  read strobe, active low
//   slwr      out  1  write strobe, active low
//   pkt_end   out  1  commit short IN packet, active low
//   tx_data   in   8  IN byte from writer
//   tx_valid  in   1  writer has a byte; held until accepted
//   tx_last   in   1  tx_data is last byte of packet (qualified by tx_valid)
//   tx_ready  out  1  one-cycle accept; transfer when tx_valid & tx_ready
//   rx_data   out  8  OUT byte to reader
//   rx_valid  out  1  one-cycle pulse, rx_data valid
//   rx_ready  in   1  reader can accept a byte this cycle
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, faddr=OUT_ADDR, sloe=slrd=slwr=pkt_end=1,
//   fdata high-Z, tx_ready=0, rx_valid=0, rx_data=0, burst=0, last_dir=IN.
//   All outputs registered (glitch-free strobes). In-flight byte dropped, no pkt_end.
//   States (one-hot): IDLE SEL_OUT OUT_CHECK OUT_STROBE SEL_IN IN_CHECK IN_SETUP
//   IN_WRITE PKTEND.
//   IDLE: want_out=flaga&rx_ready; want_in=tx_valid&flagd. Only one -> that side.
//     Both -> side != last_dir (first tie after reset goes OUT). None -> stay.
//     Leaving IDLE clears burst, sets last_dir to granted side.
//   SEL_OUT: faddr=OUT_ADDR, sloe=0, fdata Z; TURNAROUND cycles, then OUT_CHECK.
//   OUT_CHECK: if !flaga | !rx_ready | burst==MAX_BURST -> IDLE (sloe=1 on exit);
//     else -> OUT_STROBE.
//   OUT_STROBE: rx_data<=fdata, rx_valid=1 and slrd=0 for exactly this one cycle;
//     burst++; -> OUT_CHECK. Peak OUT rate 1 byte / 2 clk.
//   SEL_IN: faddr=IN_ADDR, sloe=1, fdata driven; TURNAROUND cycles -> IN_CHECK.
//   IN_CHECK: !tx_valid | burst==MAX_BURST -> IDLE; else !flagd (full): if
//     want_out -> IDLE, else wait; else -> IN_SETUP.
//   IN_SETUP: tx_ready=1 one cycle; fdata<=tx_data, last_q<=tx_last; -> IN_WRITE.
//   IN_WRITE: slwr=0 one cycle; burst++; last_q -> PKTEND else -> IN_CHECK.
//   PKTEND: pkt_end=0 one cycle (fdata still driven); -> IDLE.
//   Burst limit ends a grant without pkt_end; partial packet resumes later.
//   burst counter width $clog2(MAX_BURST+1), never wraps (saturates at limit).
//   fdata tri-state enable asserted only in SEL_IN..PKTEND; never with sloe=0.
// STRUCTURE
//   Package fx2_fifo_pkg: state one-hot localparams, EP2/EP6 address constants,
//   direction encoding (DIR_OUT/DIR_IN). Flat module; tri-state buffer inline,
//   no sub-module needed.
// TESTING
//   1 OUT only: flaga=1, rx_ready=1, EP2 model holds 5 bytes 0x10..0x14 then empty
//     -> 5 rx_valid pulses with 0x10..0x14, 5 slrd pulses, sloe=1 after, IDLE.
//   2 IN packet: 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), flagd=1 -> 3 slwr pulses
//     with fdata matching, one pkt_end pulse after 3rd slwr, faddr=2'b10.
//   3 Contention: both sides requesting continuously, MAX_BURST=4 -> grants
//     alternate OUT,IN,OUT..., each grant exactly 4 strobes, first grant OUT.
//   4 Full stall: flagd=0 mid-packet, no OUT demand -> slwr stays 1, tx_ready 0;
//     flagd=1 -> writing resumes with next byte, no byte lost or duplicated.
//   5 Full with OUT demand: flagd=0, flaga=1 -> IN grant released, OUT served.
//   6 Reset mid-IN_WRITE -> same cycle all strobes 1, fdata Z; after release
//     first tie goes OUT.

Source files
------------

// File: rtl/fx2_fifo_pkg.sv
// Shared types and constants for the FX2 slave-FIFO arbiter: one-hot state
// encoding, endpoint addresses and transfer direction.
package fx2_fifo_pkg;

  typedef enum logic [8:0] {
    ST_IDLE       = 9'b0_0000_0001,
    ST_SEL_OUT    = 9'b0_0000_0010,
    ST_OUT_CHECK  = 9'b0_0000_0100,
    ST_OUT_STROBE = 9'b0_0000_1000,
    ST_SEL_IN     = 9'b0_0001_0000,
    ST_IN_CHECK   = 9'b0_0010_0000,
    ST_IN_SETUP   = 9'b0_0100_0000,
    ST_IN_WRITE   = 9'b0_1000_0000,
    ST_PKTEND     = 9'b1_0000_0000
  } state_e;

  typedef enum logic {
    DIR_OUT = 1'b0,
    DIR_IN  = 1'b1
  } dir_e;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

endpackage

// File: rtl/fx2_fifo_arbiter.sv
// Round-robin arbiter sharing the FX2 slave-FIFO bus between an EP2 OUT reader
// and an EP6 IN writer; every pin-facing output comes straight from a flop.
module fx2_fifo_arbiter
  import fx2_fifo_pkg::*;
#(
  parameter int         MAX_BURST  = 64,
  parameter int         TURNAROUND = 2,
  parameter logic [1:0] OUT_ADDR   = EP2_ADDR,
  parameter logic [1:0] IN_ADDR    = EP6_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flaga,
  input  logic       flagd,
  inout  wire  [7:0] fdata,
  output logic [1:0] faddr,
  output logic       sloe,
  output logic       slrd,
  output logic       slwr,
  output logic       pkt_end,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
  localparam logic [TW-1:0] TA_LAST     = TW'(TURNAROUND - 1);

  state_e          state_q, state_d;
  dir_e            last_dir_q, last_dir_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [TW-1:0]   ta_q, ta_d;
  logic            last_q, last_d;
  logic [7:0]      fdata_q, fdata_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [1:0]      faddr_q, faddr_d;
  logic            oe_q, oe_d;
  logic            sloe_q, sloe_d;
  logic            slrd_q, slrd_d;
  logic            slwr_q, slwr_d;
  logic            pkt_end_q, pkt_end_d;
  logic            tx_ready_q, tx_ready_d;
  logic            rx_valid_q, rx_valid_d;

  logic want_out, want_in, burst_full;

  assign want_out   = flaga & rx_ready;
  assign want_in    = tx_valid & flagd;
  assign burst_full = (burst_q == BURST_LIMIT);

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    last_dir_d = last_dir_q;
    burst_d    = burst_q;
    ta_d       = ta_q;
    last_d     = last_q;
    fdata_d    = fdata_q;
    rx_data_d  = rx_data_q;

    case (state_q)
      ST_IDLE: begin
        // On a tie the side that did not hold the previous grant wins.
        if (want_out && (!want_in || last_dir_q == DIR_IN)) begin
          state_d    = ST_SEL_OUT;
          last_dir_d = DIR_OUT;
          burst_d    = '0;
          ta_d       = '0;
        end else if (want_in) begin
          state_d    = ST_SEL_IN;
          last_dir_d = DIR_IN;
          burst_d    = '0;
          ta_d       = '0;
        end
      end
      ST_SEL_OUT: begin
        if (ta_q == TA_LAST) state_d = ST_OUT_CHECK;
        else                 ta_d    = ta_q + 1'b1;
      end
      ST_OUT_CHECK: begin
        if (!want_out || burst_full) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_OUT_STROBE;
          rx_data_d = fdata;
        end
      end
      ST_OUT_STROBE: begin
        state_d = ST_OUT_CHECK;
        if (!burst_full) burst_d = burst_q + 1'b1;
      end
      ST_SEL_IN: begin
        if (ta_q == TA_LAST) state_d = ST_IN_CHECK;
        else                 ta_d    = ta_q + 1'b1;
      end
      ST_IN_CHECK: begin
        if (!tx_valid || burst_full) state_d = ST_IDLE;
        else if (!flagd)             state_d = want_out ? ST_IDLE : ST_IN_CHECK;
        else                         state_d = ST_IN_SETUP;
      end
      ST_IN_SETUP: begin
        state_d = ST_IN_WRITE;
        fdata_d = tx_data;
        last_d  = tx_last;
      end
      ST_IN_WRITE: begin
        state_d = last_q ? ST_PKTEND : ST_IN_CHECK;
        if (!burst_full) burst_d = burst_q + 1'b1;
      end
      ST_PKTEND: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the flops line up with it.
    sloe_d     = !(state_d inside {ST_SEL_OUT, ST_OUT_CHECK, ST_OUT_STROBE});
    oe_d       = state_d inside {ST_SEL_IN, ST_IN_CHECK, ST_IN_SETUP, ST_IN_WRITE, ST_PKTEND};
    faddr_d    = oe_d ? IN_ADDR : (!sloe_d ? OUT_ADDR : faddr_q);
    slrd_d     = (state_d != ST_OUT_STROBE);
    rx_valid_d = (state_d == ST_OUT_STROBE);
    tx_ready_d = (state_d == ST_IN_SETUP);
    slwr_d     = (state_d != ST_IN_WRITE);
    pkt_end_d  = (state_d != ST_PKTEND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_IN;
      burst_q    <= '0;
      ta_q       <= '0;
      last_q     <= 1'b0;
      fdata_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      faddr_q    <= OUT_ADDR;
      oe_q       <= 1'b0;
      sloe_q     <= 1'b1;
      slrd_q     <= 1'b1;
      slwr_q     <= 1'b1;
      pkt_end_q  <= 1'b1;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      burst_q    <= burst_d;
      ta_q       <= ta_d;
      last_q     <= last_d;
      fdata_q    <= fdata_d;
      rx_data_q  <= rx_data_d;
      faddr_q    <= faddr_d;
      oe_q       <= oe_d;
      sloe_q     <= sloe_d;
      slrd_q     <= slrd_d;
      slwr_q     <= slwr_d;
      pkt_end_q  <= pkt_end_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign fdata    = oe_q ? fdata_q : 8'hzz;
  assign faddr    = faddr_q;
  assign sloe     = sloe_q;
  assign slrd     = slrd_q;
  assign slwr     = slwr_q;
  assign pkt_end  = pkt_end_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
